// File: rtl/rr_mux_sched_pkg.sv
// rtl/rr_mux_sched_pkg.sv - shared constants, state type and select decode for rr_mux_sched
package rr_mux_sched_pkg;

  localparam int NREQ = 5;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] sel2onehot(input logic [SELW-1:0] s);
    sel2onehot = '0;
    if (s < SELW'(NREQ)) sel2onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_5_1.sv
// rtl/mux_5_1.sv - five-input data multiplexer, select 0..4 picks a..e
import rr_mux_sched_pkg::*;

module mux_5_1 #(
  parameter int DW = 4
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [DW-1:0]   c,
  input  logic [DW-1:0]   d,
  input  logic [DW-1:0]   e,
  input  logic [SELW-1:0] sel,
  output logic [DW-1:0]   y
);

  always_comb begin
    y = a;
    case (sel)
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/rr_mux_sched.sv
// rtl/rr_mux_sched.sv - round-robin scheduler muxing five requesters onto one ready/valid output
// Optional RR_MUX_SCHED_LOCK_EN adds a per-requester lock input that keeps the grant on the winner.
import rr_mux_sched_pkg::*;

module rr_mux_sched #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      req,
`ifdef RR_MUX_SCHED_LOCK_EN
  input  logic [4:0]      lock,
`endif
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  input  logic [DW-1:0]   C,
  input  logic [DW-1:0]   D,
  input  logic [DW-1:0]   E,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] sel,
  output logic [4:0]      gnt,
  output logic [4:0]      ack
);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] nxt_ptr;
  logic [SELW-1:0] win;
  logic [SELW-1:0] base;
  logic [4:0]      cand;
  logic [3:0]      idx;
  logic            found;
  logic            relock;
  logic [DW-1:0]   mux_y;

`ifdef RR_MUX_SCHED_LOCK_EN
  assign relock = (state == HOLD) && lock[sel] && req[sel];
`else
  assign relock = 1'b0;
`endif

  assign nxt_ptr = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
  assign ack     = (out_valid && out_ready) ? gnt : 5'b0;

  // In HOLD the search looks ahead to the transfer edge: it starts past the
  // current winner and excludes its bit, so a grant can follow without a bubble.
  always_comb begin
    base  = (state == HOLD) ? nxt_ptr : ptr;
    cand  = (state == HOLD) ? (req & ~gnt) : req;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, base} + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && cand[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    if (relock) begin
      found = 1'b1;
      win   = sel;
    end
  end

  mux_5_1 #(.DW(DW)) u_mux (
    .a   (A),
    .b   (B),
    .c   (C),
    .d   (D),
    .e   (E),
    .sel (win),
    .y   (mux_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= HOLD;
            sel       <= win;
            gnt       <= sel2onehot(win);
            out_data  <= mux_y;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (!relock) ptr <= nxt_ptr;
            if (found) begin
              sel      <= win;
              gnt      <= sel2onehot(win);
              out_data <= mux_y;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_sched.sv
// tb/tb_rr_mux_sched.sv - directed bench for rr_mux_sched with a rotation-order reference model
// Exercises RR_MUX_SCHED_LOCK_EN when that macro is defined for the build.
module tb_rr_mux_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req;
  logic [4:0] lock;
  logic [3:0] A, B, C, D, E;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] sel;
  logic [4:0] gnt;
  logic [4:0] ack;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  rr_mux_sched #(.DW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
`ifdef RR_MUX_SCHED_LOCK_EN
    .lock      (lock),
`endif
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .E         (E),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack)
  );

  // Reference: a transfer slot holding one captured word; winners are found by
  // walking requesters in rotation order starting at the pointer.
  int         m_valid, m_sel, m_data, m_ptr;

  function automatic int word_of(int i);
    case (i)
      0: return int'(A);
      1: return int'(B);
      2: return int'(C);
      3: return int'(D);
      default: return int'(E);
    endcase
  endfunction

  function automatic int pick(int start, logic [4:0] r);
    for (int k = 0; k < 5; k++) begin
      if (r[(start + k) % 5]) return (start + k) % 5;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int w, np;
    logic keep;
    if (reset) begin
      m_valid <= 0; m_sel <= 0; m_data <= 0; m_ptr <= 0;
    end else if (m_valid == 0) begin
      w = pick(m_ptr, req);
      if (w >= 0) begin
        m_valid <= 1; m_sel <= w; m_data <= word_of(w);
      end
    end else if (out_ready) begin
      keep = 1'b0;
`ifdef RR_MUX_SCHED_LOCK_EN
      keep = lock[m_sel] && req[m_sel];
`endif
      if (keep) begin
        m_data <= word_of(m_sel);
      end else begin
        np = (m_sel + 1) % 5;
        m_ptr <= np;
        w = pick(np, req & ~(5'b1 << m_sel));
        if (w >= 0) begin
          m_sel <= w; m_data <= word_of(w);
        end else begin
          m_valid <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] mg;
    mg = (m_valid != 0) ? (5'b1 << m_sel) : 5'b0;
    check("model out_valid", 32'(out_valid), 32'(m_valid));
    check("model sel", 32'(sel), 32'(m_sel));
    check("model gnt", 32'(gnt), 32'(mg));
    check("model out_data", 32'(out_data), 32'(m_data));
    check("model ack", 32'(ack), 32'((m_valid != 0 && out_ready) ? mg : 5'b0));
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; out_ready = 1'b0;
    A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4; E = 4'h5;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sel", 32'(sel), 32'd0);
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;

    // single request on C
    req = 5'b00100; out_ready = 1'b1;
    cycle();
    check("C out_valid", 32'(out_valid), 32'd1);
    check("C sel", 32'(sel), 32'd2);
    check("C out_data", 32'(out_data), 32'h3);
    check("C ack", 32'(ack), 32'b00100);
    cycle();
    check("C idle out_valid", 32'(out_valid), 32'd0);
    check("C idle gnt", 32'(gnt), 32'd0);
    check("C idle out_data kept", 32'(out_data), 32'h3);
    req = '0;

    // all requesting: A..E..A with no bubble
    do_reset();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("rr sel", 32'(sel), 32'(k % 5));
      check("rr out_valid", 32'(out_valid), 32'd1);
      check("rr out_data", 32'(out_data), 32'((k % 5) + 1));
    end
    req = '0;

    // stall on B while its data changes
    do_reset();
    out_ready = 1'b0; req = 5'b00010; B = 4'hF;
    cycle();
    check("stall sel", 32'(sel), 32'd1);
    B = 4'h0; req = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall out_data", 32'(out_data), 32'hF);
      check("stall ack", 32'(ack), 32'd0);
      check("stall out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("stall ack pulse", 32'(ack), 32'b00010);
    cycle();
    check("stall done ack", 32'(ack), 32'd0);
    check("stall done out_valid", 32'(out_valid), 32'd0);
    B = 4'h2;

    // persistent single requester gets an idle cycle between grants
    do_reset();
    req = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("solo out_valid", 32'(out_valid), 32'((k % 2) == 0));
    end

    // pointer wrap after E
    do_reset();
    req = 5'b10000;
    cycle();
    check("wrap E sel", 32'(sel), 32'd4);
    req = 5'b00001;
    cycle();
    check("wrap A sel", 32'(sel), 32'd0);
    check("wrap A out_valid", 32'(out_valid), 32'd1);
    req = '0;

    // reset in the middle of HOLD
    do_reset();
    out_ready = 1'b0; req = 5'b00100;
    cycle();
    check("midreset hold", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1; out_ready = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset gnt", 32'(gnt), 32'd0);
    check("midreset ack", 32'(ack), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    req = 5'b11111;
    @(negedge clk); #1;
    reset = 1'b0;
    cycle();
    check("post reset sel", 32'(sel), 32'd0);
    req = '0;

`ifdef RR_MUX_SCHED_LOCK_EN
    do_reset();
    lock = 5'b01000; req = 5'b11000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("lock D sel", 32'(sel), 32'd3);
      check("lock D out_valid", 32'(out_valid), 32'd1);
    end
    lock = '0;
    cycle();
    check("unlock E sel", 32'(sel), 32'd4);
    req = '0;
`endif

    cycle();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
